// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: main control FSM of the multicycle RV32I core.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (unknown opcodes halt the core).
`default_nettype none

module multicycle_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_op,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             illegal
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_JAL, S_ALUWB, S_BRANCH
`ifdef CTRL_ILLEGAL_TRAP_EN
        , S_HALT
`endif
    } state_t;

    state_t state, state_nx;
    logic   pc_update, branch, take;
    logic   unused_funct3;

    assign unused_funct3 = ^funct3[2:1];
    assign take          = zero ^ funct3[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_FETCH;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        alu_op     = 2'b00;
        retire     = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_update = 1'b1;
                    state_nx  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_nx = S_MEMADR;
                    OP_RTYPE:          state_nx = S_EXECR;
                    OP_ITYPE:          state_nx = S_EXECI;
                    OP_JAL:            state_nx = S_JAL;
                    OP_BRANCH:         state_nx = S_BRANCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:           state_nx = S_HALT;
`else
                    default:           state_nx = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_nx  = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_nx = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_nx   = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) begin
                    retire   = 1'b1;
                    state_nx = S_FETCH;
                end
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_nx  = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_nx  = S_ALUWB;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_nx  = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_nx  = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
                retire    = 1'b1;
                state_nx  = S_FETCH;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_HALT: begin
                illegal = 1'b1;
            end
`endif
            default: state_nx = S_FETCH;
        endcase
        pc_write = pc_update | (branch & take);
        // Reset is asynchronous, so strobes must be squashed combinationally too.
        if (!rst) begin
            mem_req   = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            retire    = 1'b0;
            illegal   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        instret <= '0;
        else if (retire) instret <= instret + CNT_W'(1);
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
// Directed self-checking bench for multicycle_control_fsm (CNT_W=32 and CNT_W=4 instances).
`default_nettype none

module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, retire, illegal;
    logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
    logic [31:0] instret;

    logic       mem_req4, mem_write4, adr_src4, ir_write4, pc_write4, reg_write4, retire4, illegal4;
    logic [1:0] alu_src_a4, alu_src_b4, result_src4, alu_op4;
    logic [3:0] instret4;

    logic [15:0] outs;

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, ADD = 7'b0110011;
    localparam logic [6:0] ADDI = 7'b0010011, JAL = 7'b1101111, BR = 7'b1100011;

    // {mem_req,mem_write,adr_src,ir_write,pc_write,reg_write,a,b,res,aluop,retire,illegal}
    localparam logic [15:0] E_RST   = 16'h00A0;
    localparam logic [15:0] E_FETCH = 16'h98A0;
    localparam logic [15:0] E_FWAIT = 16'h80A0;
    localparam logic [15:0] E_DEC   = 16'h0140;
    localparam logic [15:0] E_MADR  = 16'h0240;
    localparam logic [15:0] E_MRD   = 16'hA000;
    localparam logic [15:0] E_MWB   = 16'h0412;
    localparam logic [15:0] E_MWRW  = 16'hE000;
    localparam logic [15:0] E_MWR   = 16'hE002;
    localparam logic [15:0] E_EXR   = 16'h0208;
    localparam logic [15:0] E_EXI   = 16'h0248;
    localparam logic [15:0] E_JAL   = 16'h0980;
    localparam logic [15:0] E_ALUWB = 16'h0402;
    localparam logic [15:0] E_BRT   = 16'h0A06;
    localparam logic [15:0] E_BRN   = 16'h0206;
    localparam logic [15:0] E_HALT  = 16'h0001;

    assign outs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                   alu_src_a, alu_src_b, result_src, alu_op, retire, illegal};

    multicycle_control_fsm #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .alu_op(alu_op), .retire(retire), .instret(instret),
        .illegal(illegal)
    );

    multicycle_control_fsm #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req4), .mem_write(mem_write4), .adr_src(adr_src4), .ir_write(ir_write4),
        .pc_write(pc_write4), .reg_write(reg_write4), .alu_src_a(alu_src_a4),
        .alu_src_b(alu_src_b4), .result_src(result_src4), .alu_op(alu_op4), .retire(retire4),
        .instret(instret4), .illegal(illegal4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [6:0] o, input logic [2:0] f3, input logic z,
                       input logic rdy, input logic [15:0] exp, input string tag);
        @(negedge clk);
        op = o; funct3 = f3; zero = z; mem_ready = rdy;
        #1;
        chk(tag, {16'h0, outs}, {16'h0, exp});
    endtask

    initial begin
        // reset state, with mem_ready high to show strobes stay masked
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        chk("rst_outs", {16'h0, outs}, {16'h0, E_RST});
        chk("rst_instret", instret, 32'd0);
        chk("rst_instret4", {28'h0, instret4}, 32'd0);
        mem_ready = 1'b0;
        rst = 1'b1;

        // add: 4 cycles
        cyc(ADD, 3'b000, 1'b0, 1'b1, E_FETCH, "add_fetch");
        cyc(ADD, 3'b000, 1'b0, 1'b1, E_DEC,   "add_decode");
        cyc(ADD, 3'b000, 1'b0, 1'b1, E_EXR,   "add_execr");
        cyc(ADD, 3'b000, 1'b0, 1'b1, E_ALUWB, "add_aluwb");

        // lw with 2 fetch stalls and 3 memread stalls: 10 cycles
        cyc(LW, 3'b010, 1'b0, 1'b0, E_FWAIT, "lw_fetch_wait0");
        chk("add_instret", instret, 32'd1);
        cyc(LW, 3'b010, 1'b0, 1'b0, E_FWAIT, "lw_fetch_wait1");
        cyc(LW, 3'b010, 1'b0, 1'b1, E_FETCH, "lw_fetch");
        cyc(LW, 3'b010, 1'b0, 1'b0, E_DEC,   "lw_decode");
        cyc(LW, 3'b010, 1'b0, 1'b0, E_MADR,  "lw_memadr");
        for (int i = 0; i < 3; i++)
            cyc(LW, 3'b010, 1'b0, 1'b0, E_MRD, "lw_memread_wait");
        cyc(LW, 3'b010, 1'b0, 1'b1, E_MRD,   "lw_memread");
        cyc(LW, 3'b010, 1'b0, 1'b0, E_MWB,   "lw_memwb");

        // beq taken, bne not taken (zero=1 for both)
        cyc(BR, 3'b000, 1'b1, 1'b1, E_FETCH, "beq_fetch");
        chk("lw_instret", instret, 32'd2);
        cyc(BR, 3'b000, 1'b1, 1'b1, E_DEC,   "beq_decode");
        cyc(BR, 3'b000, 1'b1, 1'b1, E_BRT,   "beq_branch");
        cyc(BR, 3'b001, 1'b1, 1'b1, E_FETCH, "bne_fetch");
        cyc(BR, 3'b001, 1'b1, 1'b1, E_DEC,   "bne_decode");
        cyc(BR, 3'b001, 1'b1, 1'b1, E_BRN,   "bne_branch");

        // sw with one memwrite stall
        cyc(SW, 3'b010, 1'b0, 1'b1, E_FETCH, "sw_fetch");
        chk("br_instret", instret, 32'd4);
        cyc(SW, 3'b010, 1'b0, 1'b1, E_DEC,   "sw_decode");
        cyc(SW, 3'b010, 1'b0, 1'b1, E_MADR,  "sw_memadr");
        cyc(SW, 3'b010, 1'b0, 1'b0, E_MWRW,  "sw_memwrite_wait");
        cyc(SW, 3'b010, 1'b0, 1'b1, E_MWR,   "sw_memwrite");

        // addi and jal
        cyc(ADDI, 3'b000, 1'b0, 1'b1, E_FETCH, "addi_fetch");
        chk("sw_instret", instret, 32'd5);
        cyc(ADDI, 3'b000, 1'b0, 1'b1, E_DEC,   "addi_decode");
        cyc(ADDI, 3'b000, 1'b0, 1'b1, E_EXI,   "addi_execi");
        cyc(ADDI, 3'b000, 1'b0, 1'b1, E_ALUWB, "addi_aluwb");
        cyc(JAL, 3'b000, 1'b0, 1'b1, E_FETCH,  "jal_fetch");
        cyc(JAL, 3'b000, 1'b0, 1'b1, E_DEC,    "jal_decode");
        cyc(JAL, 3'b000, 1'b0, 1'b1, E_JAL,    "jal_jal");
        cyc(JAL, 3'b000, 1'b0, 1'b1, E_ALUWB,  "jal_aluwb");

        // reset asserted mid-MEMREAD
        cyc(LW, 3'b010, 1'b0, 1'b1, E_FETCH, "lwr_fetch");
        chk("jal_instret", instret, 32'd7);
        cyc(LW, 3'b010, 1'b0, 1'b1, E_DEC,   "lwr_decode");
        cyc(LW, 3'b010, 1'b0, 1'b1, E_MADR,  "lwr_memadr");
        cyc(LW, 3'b010, 1'b0, 1'b0, E_MRD,   "lwr_memread");
        #1 rst = 1'b0;
        #1;
        chk("midrst_outs", {16'h0, outs}, {16'h0, E_RST});
        chk("midrst_instret", instret, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cyc(LW, 3'b010, 1'b0, 1'b0, E_FWAIT, "postrst_fetch");

        // unrecognised opcode
        cyc(7'b0000000, 3'b000, 1'b0, 1'b1, E_FETCH, "ill_fetch");
        cyc(7'b0000000, 3'b000, 1'b0, 1'b1, E_DEC,   "ill_decode");
`ifdef CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 20; i++)
            cyc(7'b0000000, 3'b000, 1'b0, 1'b1, E_HALT, "ill_halt");
`else
        cyc(7'b0000000, 3'b000, 1'b0, 1'b1, E_FETCH, "ill_back_fetch");
`endif
        chk("ill_instret", instret, 32'd0);
        mem_ready = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // counter wrap on the 4-bit instance
        for (int i = 0; i < 15; i++) begin
            cyc(BR, 3'b000, 1'b0, 1'b1, E_FETCH, "wrap_fetch");
            cyc(BR, 3'b000, 1'b0, 1'b1, E_DEC,   "wrap_decode");
            cyc(BR, 3'b000, 1'b0, 1'b1, E_BRN,   "wrap_branch");
        end
        cyc(BR, 3'b000, 1'b0, 1'b1, E_FETCH, "wrap15_fetch");
        chk("wrap_instret4_15", {28'h0, instret4}, 32'd15);
        chk("wrap_instret_15", instret, 32'd15);
        cyc(BR, 3'b000, 1'b0, 1'b1, E_DEC,   "wrap16_decode");
        cyc(BR, 3'b000, 1'b0, 1'b1, E_BRN,   "wrap16_branch");
        cyc(BR, 3'b000, 1'b0, 1'b0, E_FWAIT, "wrap16_fetch");
        chk("wrap_instret4_0", {28'h0, instret4}, 32'd0);
        chk("wrap_instret_16", instret, 32'd16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main control state machine for the multicycle variant of the RV32I core. Sequences the shared ALU, instruction register, PC and register-file strobes over several cycles per instruction. Drives the 2-bit ALUOp consumed by the existing ALU decoder, so one ALU serves PC+4, branch-target, address and execute computations. Stalls on a single-port memory through a req/ready handshake and counts retired instructions.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- op  in  7  opcode from instruction register
- funct3  in  3  instruction funct3; bit 0 selects BNE over BEQ
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  store strobe, valid with mem_req
- adr_src  out  1  0 = PC, 1 = ALU result register
- ir_write  out  1  load instruction register and OldPC
- pc_write  out  1  load PC
- reg_write  out  1  register-file write enable
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1 data
- alu_src_b  out  2  00 rs2 data, 01 ImmExt, 10 constant 4
- result_src  out  2  00 ALUOut register, 01 memory data, 10 ALU result
- alu_op  out  2  00 add, 01 subtract, 10 funct-decoded
- retire  out  1  one-cycle pulse per completed instruction
- instret  out  CNT_W  retired-instruction count
- illegal  out  1  illegal-opcode halt flag

## Operation
- Moore outputs decoded from state. Exception: pc_write = pc_update | (branch & take), with take = zero ^ funct3[0].
- Defaults are 0 for all strobes and selects unless listed below.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write and pc_update only when mem_ready=1.
  - mem_ready=1 -> DECODE; otherwise hold.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch/JAL target). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1101111 -> JAL
  - 1100011 -> BRANCH
  - anything else -> see Configuration.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next: op[5] ? MEMWRITE : MEMREAD.
- MEMREAD: mem_req=1, adr_src=1. mem_ready=1 -> MEMWB; otherwise hold.
- MEMWB: result_src=01, reg_write=1, retire=1 -> FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. mem_ready=1 -> FETCH with retire=1; otherwise hold.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10 -> ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10 -> ALUWB.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1 -> ALUWB.
- ALUWB: result_src=00, reg_write=1, retire=1 -> FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1, retire=1 -> FETCH.
- instret increments by 1 on every cycle where retire=1. Wraps modulo 2^CNT_W with no saturation.

## Timing
- While rst=0: state=FETCH, instret=0, illegal=0. mem_req, mem_write, ir_write, pc_write, reg_write and retire are forced to 0. Selects show FETCH values.
- Reset asserted mid-instruction aborts it immediately. No retire and no strobes are issued. The first cycle after deassertion is FETCH.
- Latency from FETCH entry, with mem_ready high on first request:
  - R-type, I-type ALU, JAL: 4 cycles
  - branch: 3 cycles
  - load: 5 cycles
  - store: 4 cycles
- Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds one cycle. Outputs stay stable while held.
- mem_ready is ignored in every other state.
- retire is a registered-state decode and is coincident with the final strobe of the instruction. instret shows the new value the cycle after.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined:
  - An unrecognised op in DECODE enters HALT.
  - In HALT, illegal=1 and all strobes are 0. HALT holds until reset; no retire.
- CTRL_ILLEGAL_TRAP_EN undefined:
  - An unrecognised op in DECODE returns to FETCH as a no-op, without retire.
  - illegal is tied to 0 and the HALT state does not exist.

## Test plan
- add x3,x1,x2 (op 0110011), mem_ready always 1 -> states FETCH, DECODE, EXECR, ALUWB. alu_op=10 in EXECR. reg_write=1 only in cycle 4. instret 0 -> 1.
- lw (0000011) with mem_ready low 2 cycles in FETCH and 3 in MEMREAD -> 10 cycles total. ir_write pulses once. reg_write with result_src=01 in MEMWB.
- beq with zero=1, then bne (funct3=001) with zero=1 -> pc_write=1 in BRANCH for beq only. alu_op=01 in both. instret +2.
- sw (0100011) -> mem_write=1 only in MEMWRITE with adr_src=1. No reg_write. retire on the mem_ready cycle.
- rst driven low during MEMREAD with mem_req high -> mem_req drops in the same cycle. instret=0. FETCH after release.
- op=0000000:
  - with CTRL_ILLEGAL_TRAP_EN: illegal=1 and stuck in HALT for 20 cycles.
  - without: back to FETCH, instret unchanged.
- Separately, preload instret to 2^CNT_W-1 using CNT_W=4 and retire 1 instruction -> wraps to 0.
